hsfir_decim: RTL and testbench
==============================

# hsfir_decim

Parametrised half-band FIR filter with optional decimate-by-2 and a runtime-loadable coefficient bank. It is the next generation of the fixed 8-bit cheap half-band filter. The input and output widths, the coefficient width and the tap count are configurable. Sample-valid strobes, convergent rounding and saturation are added. The block sits between an upstream sample source (ADC front end or CIC stage) and downstream DSP, in the single system clock domain.

## Interface

- IW, 12, input sample width (signed)
- OW, 12, output sample width (signed)
- CW, 16, coefficient width (signed, value = c / 2^(CW-1))
- NCOEF, 3, unique non-centre coefficients; tap count NTAPS = 4*NCOEF-1 (default 11)

- i_clk  in  1  system clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_ce  in  1  input sample valid; one sample per high cycle
- i_data  in  IW  signed input sample
- i_dec  in  1  1 = decimate by 2, 0 = full-rate output
- i_coef_we  in  1  coefficient write strobe
- i_coef_addr  in  clog2(NCOEF) (min 1)  coefficient index k
- i_coef_data  in  CW  signed coefficient value
- o_ce  out  1  output sample valid, one-cycle pulse
- o_data  out  OW  signed filtered sample
- o_sat  out  1  high with o_ce when o_data was clipped

## Operation

- Delay line of NTAPS signed IW registers. It shifts only on i_ce and is zero after reset.
- Impulse response h[n], n=0..NTAPS-1, centre C=2*NCOEF-1:
  - h[C] = 0.5 fixed, implemented as a shift with no multiplier.
  - h[C±(2k+1)] = coef[k] for k=0..NCOEF-1.
  - All other even-offset taps are 0 and are never computed.
- Pipeline: pre-add the symmetric pairs (IW+1 bits), multiply by coef[k] (IW+CW+1), sum the NCOEF products plus centre<<(CW-2) into an accumulator of width AW = IW+CW+clog2(NCOEF)+2, scale, round, saturate.
- Scaling: result = acc / 2^(CW-1), so unity coefficient scale gives unity gain.
- Rounding: convergent (round half to even) on the discarded CW-1 bits.
- Saturation: clip to [-2^(OW-1), 2^(OW-1)-1]; o_sat=1 on the clipped sample only.
- Coefficients:
  - NCOEF registers, all 0 after reset (filter then equals 0.5·x delayed by C samples).
  - A write at edge W with i_coef_addr < NCOEF updates coef[addr]. Writes with addr ≥ NCOEF are ignored.
  - A multiply stage at edge W uses the old value; multiplies at later edges use the new value. No handshake: writes are legal at any time, and outputs in flight may mix old and new values.
- Decimation:
  - A 1-bit phase toggles on every i_ce while i_dec=1.
  - Only samples accepted with phase=1 (the 2nd, 4th, …) produce o_ce. Phase is 0 after reset.
  - While i_dec=0, phase is held at 0 and every accepted sample produces o_ce.
  - i_dec is sampled with i_ce.

## Timing

- Reset (async assert, sync-safe release): o_ce=0, o_data=0, o_sat=0; delay line, pipeline, phase and coefficients cleared. Reset mid-stream discards all in-flight samples; no o_ce follows from pre-reset input.
- Latency: sample captured at edge E0 → o_ce/o_data/o_sat registered at edge E0+4 (stages: capture, pre-add, multiply, sum, round/sat).
- Pipeline stages after capture run every clock, tagged with a valid bit. Latency is fixed regardless of i_ce spacing; i_ce high every cycle gives an output every cycle (dec=0) or every 2nd cycle (dec=1).
- o_data holds its last value between o_ce pulses; o_sat is 0 whenever o_ce=0.
- Simultaneous i_ce and i_coef_we: both take effect; the new coefficient applies to this sample only if its multiply stage is after W (it always is, since the multiply occurs at E0+2).

## Test plan

- Reset: hold i_reset_n=0 with i_ce toggling → o_ce=0, o_data=0, o_sat=0 throughout. Assert reset mid-stream → no o_ce after release until a new sample is 4 edges old.
- Impulse, dec=0: load coef0=8192, coef1=-4096, coef2=2048; feed 64 followed by zeros → o_data = 4,0,-8,0,16,32,16,0,-8,0,4, then 0s. The first value appears 4 edges after capturing the 64.
- Rounding, coefs=0: feed 3, 5, -3, -5, 7 → 2, 2, -2, -2, 4.
- Saturation: coef0=32767, others 0; DC input 2047 → settles at o_data=2047 with o_sat=1. DC input -2048 → -2048 with o_sat=1. Input 100 → o_sat=0.
- Decimation: dec=1, i_ce every cycle, impulse test above → one o_ce per two inputs, values 4,-8,16,16,-8,4 (odd-phase samples only). Toggle dec to 0 → phase resets and an output follows every sample.
- Coefficient write timing: write coef0 during a continuous DC-64 stream with i_ce every cycle → output moves from the old to the new steady state without glitches to unrelated values. Writes to addr 3 leave all coefficients unchanged.

Source files
------------

// File: rtl/hsfir_decim.sv
// hsfir_decim: half-band FIR with runtime-loadable coefficients, convergent
// rounding, saturation and optional decimate-by-2.
module hsfir_decim #(
    parameter int IW    = 12,
    parameter int OW    = 12,
    parameter int CW    = 16,
    parameter int NCOEF = 3,
    parameter int AB    = (NCOEF > 1) ? $clog2(NCOEF) : 1
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_ce,
    input  logic [IW-1:0] i_data,
    input  logic          i_dec,
    input  logic          i_coef_we,
    input  logic [AB-1:0] i_coef_addr,
    input  logic [CW-1:0] i_coef_data,
    output logic          o_ce,
    output logic [OW-1:0] o_data,
    output logic          o_sat
);
    localparam int NT = 4*NCOEF-1;
    localparam int C  = 2*NCOEF-1;
    localparam int PW = IW+1;
    localparam int MW = IW+CW+1;
    localparam int AW = IW+CW+$clog2(NCOEF)+2;
    localparam int F  = CW-1;
    localparam int RW = AW-F+1;
    localparam logic signed [RW-1:0] OMAX = RW'((2**(OW-1))-1);
    localparam logic signed [RW-1:0] OMIN = ~OMAX;

    logic signed [IW-1:0] tap_q [NT];
    logic signed [CW-1:0] coef_q [NCOEF];
    logic signed [PW-1:0] pre_q [NCOEF];
    logic signed [MW-1:0] prod_q [NCOEF];
    logic signed [IW-1:0] ctr1_q, ctr2_q;
    logic signed [AW-1:0] acc_q, acc_d;
    logic        [3:0]    vld_q;
    logic                 phase_q;
    logic                 o_ce_q, o_sat_q;
    logic        [OW-1:0] o_data_q, o_data_d;
    logic signed [RW-1:0] flr, res;
    logic                 up, hi, lo;

    always_comb begin
        acc_d = AW'(ctr2_q) <<< (CW-2);
        for (int k = 0; k < NCOEF; k++) acc_d = acc_d + AW'(prod_q[k]);
        flr = RW'(acc_q >>> F);
        // round half to even: bump when discarded part exceeds half, or equals half with odd quotient
        up = acc_q[F-1] & ((|acc_q[F-2:0]) | flr[0]);
        res = flr + RW'(up);
        hi = res > OMAX;
        lo = res < OMIN;
        o_data_d = hi ? OW'(OMAX) : lo ? OW'(OMIN) : OW'(res);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int n = 0; n < NT; n++) tap_q[n] <= '0;
            for (int k = 0; k < NCOEF; k++) begin
                coef_q[k] <= '0;
                pre_q[k]  <= '0;
                prod_q[k] <= '0;
            end
            ctr1_q   <= '0;
            ctr2_q   <= '0;
            acc_q    <= '0;
            vld_q    <= '0;
            phase_q  <= 1'b0;
            o_ce_q   <= 1'b0;
            o_sat_q  <= 1'b0;
            o_data_q <= '0;
        end else begin
            if (i_ce) begin
                tap_q[0] <= i_data;
                for (int n = 1; n < NT; n++) tap_q[n] <= tap_q[n-1];
            end
            if (i_coef_we && int'(i_coef_addr) < NCOEF) coef_q[i_coef_addr] <= i_coef_data;
            phase_q <= i_dec & (phase_q ^ i_ce);
            vld_q   <= {vld_q[2:0], i_ce & (~i_dec | phase_q)};
            for (int k = 0; k < NCOEF; k++) begin
                pre_q[k]  <= PW'(tap_q[C-1-2*k]) + PW'(tap_q[C+1+2*k]);
                prod_q[k] <= MW'(pre_q[k]) * MW'(coef_q[k]);
            end
            ctr1_q  <= tap_q[C];
            ctr2_q  <= ctr1_q;
            acc_q   <= acc_d;
            o_ce_q  <= vld_q[3];
            o_sat_q <= vld_q[3] & (hi | lo);
            if (vld_q[3]) o_data_q <= o_data_d;
        end
    end

    assign o_ce   = o_ce_q;
    assign o_data = o_data_q;
    assign o_sat  = o_sat_q;
endmodule

// File: tb/tb_hsfir_decim.sv
// tb_hsfir_decim: randomized and directed stimulus checked each cycle against
// a convolution model built from the impulse response definition.
module tb_hsfir_decim;
    localparam int IW = 12, OW = 12, CW = 16, NCOEF = 3, AB = 2;
    localparam int NT = 4*NCOEF-1, C = 2*NCOEF-1;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          ce = 1'b0, dec = 1'b0, we = 1'b0;
    logic [IW-1:0] din = '0;
    logic [AB-1:0] waddr = '0;
    logic [CW-1:0] wdata = '0;
    logic          o_ce, o_sat;
    logic [OW-1:0] o_data;

    always #5 clk = ~clk;

    hsfir_decim #(.IW(IW), .OW(OW), .CW(CW), .NCOEF(NCOEF)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_data(din), .i_dec(dec),
        .i_coef_we(we), .i_coef_addr(waddr), .i_coef_data(wdata),
        .o_ce(o_ce), .o_data(o_data), .o_sat(o_sat)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    int hist [NT];
    int mcoef [NCOEF];
    int ch [8][NCOEF];
    int cap [8][NT];
    bit cv [8];
    bit phase = 0;
    int t = 8;
    int exp_data = 0;
    bit exp_ce = 0, exp_sat = 0;

    task automatic model_edge();
        longint acc, q, r, half, mx;
        int h [NT];
        int si, ci;
        if (!rst_n) begin
            hist = '{default: 0};
            mcoef = '{default: 0};
            cv = '{default: 0};
            phase = 0;
            exp_ce = 0;
            exp_data = 0;
            exp_sat = 0;
            return;
        end
        t++;
        ch[t%8] = mcoef;
        si = (t-4) % 8;
        ci = (t-2) % 8;
        exp_ce = cv[si];
        exp_sat = 0;
        if (cv[si]) begin
            h = '{default: 0};
            h[C] = 1 << (CW-2);
            for (int k = 0; k < NCOEF; k++) begin
                h[C-(2*k+1)] = ch[ci][k];
                h[C+(2*k+1)] = ch[ci][k];
            end
            acc = 0;
            for (int n = 0; n < NT; n++) acc += longint'(h[n]) * longint'(cap[si][n]);
            q = acc >>> (CW-1);
            r = acc - (q <<< (CW-1));
            half = longint'(1) << (CW-2);
            if (r > half || (r == half && q[0])) q++;
            mx = (longint'(1) << (OW-1)) - 1;
            if (q > mx) begin q = mx; exp_sat = 1; end
            else if (q < -mx-1) begin q = -mx-1; exp_sat = 1; end
            exp_data = int'(q);
        end
        if (we && waddr < NCOEF) mcoef[waddr] = int'($signed(wdata));
        cv[t%8] = 0;
        if (ce) begin
            for (int n = NT-1; n > 0; n--) hist[n] = hist[n-1];
            hist[0] = int'($signed(din));
            cv[t%8] = !dec || phase;
            cap[t%8] = hist;
        end
        phase = dec && (phase ^ ce);
    endtask

    task automatic step(input bit c, input int d, input bit dc,
                        input bit w = 0, input int a = 0, input int wd = 0);
        ce = c;
        din = IW'(d);
        dec = dc;
        we = w;
        waddr = AB'(a);
        wdata = CW'(wd);
        @(posedge clk);
        model_edge();
        #1;
        check("o_ce", int'(o_ce), int'(exp_ce));
        check("o_sat", int'(o_sat), int'(exp_sat));
        check("o_data", int'($signed(o_data)), exp_data);
    endtask

    int rv [5] = '{3, 5, -3, -5, 7};
    bit rdec = 0;

    initial begin
        for (int i = 0; i < 6; i++) step(bit'(i % 2), 100 + i, 0);
        rst_n = 1'b1;
        foreach (rv[i]) step(1, rv[i], 0);
        repeat (8) step(0, 0, 0);
        step(0, 0, 0, 1, 0, 8192);
        step(0, 0, 0, 1, 1, -4096);
        step(0, 0, 0, 1, 2, 2048);
        step(1, 64, 0);
        repeat (14) step(1, 0, 0);
        step(1, 0, 1);
        step(1, 64, 1);
        repeat (14) step(1, 0, 1);
        repeat (8) step(1, 0, 0);
        step(0, 0, 0, 1, 0, 32767);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 2, 0);
        repeat (20) step(1, 2047, 0);
        repeat (20) step(1, -2048, 0);
        repeat (20) step(1, 100, 0);
        step(0, 0, 0, 1, 0, 8192);
        repeat (12) step(1, 64, 0);
        step(1, 64, 0, 1, 0, 16384);
        repeat (10) step(1, 64, 0);
        step(1, 64, 0, 1, 3, 1234);
        repeat (10) step(1, 64, 0);
        repeat (3) step(1, int'($urandom_range(0, 4095)) - 2048, 0);
        rst_n = 1'b0;
        step(1, 500, 0);
        step(1, 600, 0);
        rst_n = 1'b1;
        repeat (6) step(0, 0, 0);
        repeat (6) step(1, 77, 0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) rdec = ~rdec;
            if ($urandom_range(0, 19) == 0)
                step($urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)) - 2048, rdec,
                     1, int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)) - 32768);
            else
                step($urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)) - 2048, rdec);
        end
        repeat (6) step(0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
